// File: rtl/vx_mem_req_throttle.sv
// Outstanding-read limiter for one core-to-dcache lane: a one-entry registered
// request stage gated by a read credit counter, with a combinational response path.
module vx_mem_req_throttle #(
    parameter int DATA_SIZE     = 4,
    parameter int ADDR_WIDTH    = 32,
    parameter int TAG_WIDTH     = 8,
    parameter int MAX_PENDING   = 8,
    parameter int PERF_CTR_BITS = 44,
    localparam int PEND_W       = $clog2(MAX_PENDING + 1),
    localparam int DW           = DATA_SIZE * 8
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     core_req_valid,
    output logic                     core_req_ready,
    input  logic                     core_req_rw,
    input  logic [ADDR_WIDTH-1:0]    core_req_addr,
    input  logic [DW-1:0]            core_req_data,
    input  logic [DATA_SIZE-1:0]     core_req_byteen,
    input  logic [TAG_WIDTH-1:0]     core_req_tag,

    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic                     mem_req_rw,
    output logic [ADDR_WIDTH-1:0]    mem_req_addr,
    output logic [DW-1:0]            mem_req_data,
    output logic [DATA_SIZE-1:0]     mem_req_byteen,
    output logic [TAG_WIDTH-1:0]     mem_req_tag,

    input  logic                     mem_rsp_valid,
    output logic                     mem_rsp_ready,
    input  logic [DW-1:0]            mem_rsp_data,
    input  logic [TAG_WIDTH-1:0]     mem_rsp_tag,

    output logic                     core_rsp_valid,
    input  logic                     core_rsp_ready,
    output logic [DW-1:0]            core_rsp_data,
    output logic [TAG_WIDTH-1:0]     core_rsp_tag,

    output logic [PEND_W-1:0]        pending,
    output logic                     busy,
    output logic                     rsp_underflow,
    output logic [PERF_CTR_BITS-1:0] perf_stall_cycles,
    output logic [PEND_W-1:0]        perf_max_pending
);

    localparam logic [PEND_W-1:0] MAX_P = PEND_W'(MAX_PENDING);

    logic                     stage_valid_q, stage_valid_d;
    logic                     rw_q, rw_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [DW-1:0]            data_q, data_d;
    logic [DATA_SIZE-1:0]     byteen_q, byteen_d;
    logic [TAG_WIDTH-1:0]     tag_q, tag_d;

    logic [PEND_W-1:0]        pending_q, pending_d;
    logic [PEND_W-1:0]        max_pending_q, max_pending_d;
    logic                     underflow_q, underflow_d;
    logic [PERF_CTR_BITS-1:0] stall_q, stall_d;

    logic stage_ready, credit_ok, core_fire, rd_fire, mem_fire, rsp_fire;

    always_comb begin
        stage_ready    = ~stage_valid_q | mem_req_ready;
        credit_ok      = core_req_rw | (pending_q < MAX_P);
        core_req_ready = stage_ready & credit_ok;
        core_fire      = core_req_valid & core_req_ready;
        rd_fire        = core_fire & ~core_req_rw;
        mem_fire       = stage_valid_q & mem_req_ready;
        rsp_fire       = mem_rsp_valid & core_rsp_ready;

        stage_valid_d = stage_valid_q;
        rw_d          = rw_q;
        addr_d        = addr_q;
        data_d        = data_q;
        byteen_d      = byteen_q;
        tag_d         = tag_q;
        if (core_fire) begin
            stage_valid_d = 1'b1;
            rw_d          = core_req_rw;
            addr_d        = core_req_addr;
            data_d        = core_req_data;
            byteen_d      = core_req_byteen;
            tag_d         = core_req_tag;
        end else if (mem_fire) begin
            stage_valid_d = 1'b0;
        end

        // A stray response never drives the counter below zero; it only flags.
        pending_d   = pending_q;
        underflow_d = underflow_q | (rsp_fire & (pending_q == '0));
        if (rd_fire && !rsp_fire) begin
            pending_d = pending_q + PEND_W'(1);
        end else if (rsp_fire && !rd_fire && pending_q != '0) begin
            pending_d = pending_q - PEND_W'(1);
        end

        max_pending_d = (pending_d > max_pending_q) ? pending_d : max_pending_q;

        stall_d = stall_q;
        if (core_req_valid && stage_ready && !credit_ok) begin
            stall_d = stall_q + PERF_CTR_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_valid_q <= 1'b0;
            pending_q     <= '0;
            max_pending_q <= '0;
            underflow_q   <= 1'b0;
            stall_q       <= '0;
        end else begin
            stage_valid_q <= stage_valid_d;
            pending_q     <= pending_d;
            max_pending_q <= max_pending_d;
            underflow_q   <= underflow_d;
            stall_q       <= stall_d;
        end
    end

    // Request payload carries no reset; it is qualified by stage_valid_q.
    always_ff @(posedge clk) begin
        rw_q     <= rw_d;
        addr_q   <= addr_d;
        data_q   <= data_d;
        byteen_q <= byteen_d;
        tag_q    <= tag_d;
    end

    assign mem_req_valid  = stage_valid_q;
    assign mem_req_rw     = rw_q;
    assign mem_req_addr   = addr_q;
    assign mem_req_data   = data_q;
    assign mem_req_byteen = byteen_q;
    assign mem_req_tag    = tag_q;

    assign core_rsp_valid = mem_rsp_valid;
    assign mem_rsp_ready  = core_rsp_ready;
    assign core_rsp_data  = mem_rsp_data;
    assign core_rsp_tag   = mem_rsp_tag;

    assign pending           = pending_q;
    assign busy              = (pending_q != '0) | stage_valid_q;
    assign rsp_underflow     = underflow_q;
    assign perf_stall_cycles = stall_q;
    assign perf_max_pending  = max_pending_q;

endmodule
